// File: rtl/uart_rx_controller.sv
// uart_rx_controller
// Frame sequencer for the UART receiver. Waits for a start-bit falling edge on
// the synchronized line, then walks START -> DATA -> [PARITY] -> STOP, timing
// each bit with an edge counter (0..P-1) and a data-bit counter. It strobes
// the checker/deserializer enables in the last clock of each bit. It also
// collects the parity and stop verdicts. It issues exactly one data_valid or
// frame_err pulse in the first IDLE cycle after the stop bit.
//
// Ports
//   clk, rst            receiver (oversampling) clock, async active-high reset
//   rx_in               synchronized serial line, idle high
//   prescale            oversampling ratio (8/16/32; anything else acts as 8)
//   par_en              frame carries a parity bit
//   start_glitch        start checker verdict (valid with start_check_enable)
//   par_err             parity checker verdict (valid with par_check_enable)
//   stp_err             stop checker verdict (valid with stp_check_enable)
//   edge_cnt, bit_cnt   bit timing counters
//   samp_en             data sampler enable (whole frame)
//   *_check_enable      one-cycle checker strobes at end of bit
//   deser_en            one-cycle deserializer shift strobe per data bit
//   data_valid          one-cycle pulse: frame good
//   frame_err           one-cycle pulse: frame dropped
module uart_rx_controller #(
   parameter int DATA_BITS = 8,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_in,
   input  logic [CNT_W-1:0] prescale,
   input  logic             par_en,
   input  logic             start_glitch,
   input  logic             par_err,
   input  logic             stp_err,
   output logic [CNT_W-1:0] edge_cnt,
   output logic [3:0]       bit_cnt,
   output logic             samp_en,
   output logic             start_check_enable,
   output logic             par_check_enable,
   output logic             stp_check_enable,
   output logic             deser_en,
   output logic             data_valid,
   output logic             frame_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] p_lat;     // prescale frozen for the whole frame
   logic             err_flag;  // sticky parity verdict for this frame
   logic [CNT_W-1:0] p_sel;
   logic             eob;       // last clock of the current bit
   logic             pre_eob;   // one clock before eob

   assign p_sel = (prescale == CNT_W'(8) || prescale == CNT_W'(16) ||
                   prescale == CNT_W'(32)) ? prescale : CNT_W'(8);

   assign eob     = (edge_cnt == p_lat - CNT_W'(1));
   assign pre_eob = (edge_cnt == p_lat - CNT_W'(2));

   // The strobes are registered, so they are launched one clock early
   // (pre_eob) to land exactly on the end-of-bit cycle. The state cannot
   // change between pre_eob and eob, so the current state selects the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         p_lat              <= CNT_W'(8);
         err_flag           <= 1'b0;
         edge_cnt           <= '0;
         bit_cnt            <= '0;
         samp_en            <= 1'b0;
         start_check_enable <= 1'b0;
         par_check_enable   <= 1'b0;
         stp_check_enable   <= 1'b0;
         deser_en           <= 1'b0;
         data_valid         <= 1'b0;
         frame_err          <= 1'b0;
      end else begin
         start_check_enable <= 1'b0;
         par_check_enable   <= 1'b0;
         stp_check_enable   <= 1'b0;
         deser_en           <= 1'b0;
         data_valid         <= 1'b0;
         frame_err          <= 1'b0;

         if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            if (!rx_in) begin
               state    <= START;
               p_lat    <= p_sel;
               err_flag <= 1'b0;
               samp_en  <= 1'b1;
            end
         end else begin
            edge_cnt <= eob ? '0 : edge_cnt + CNT_W'(1);

            if (pre_eob) begin
               start_check_enable <= (state == START);
               deser_en           <= (state == DATA);
               par_check_enable   <= (state == PARITY);
               stp_check_enable   <= (state == STOP);
            end

            if (eob) begin
               case (state)
                  START: begin
                     if (start_glitch) begin
                        state   <= IDLE;
                        samp_en <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_cnt <= '0;
                     end
                  end
                  DATA: begin
                     if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= par_en ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
                  PARITY: begin
                     err_flag <= par_err;
                     state    <= STOP;
                  end
                  STOP: begin
                     state   <= IDLE;
                     samp_en <= 1'b0;
                     if (err_flag || stp_err) frame_err  <= 1'b1;
                     else                     data_valid <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
